egk_bin_scheduler: RTL and testbench

//  Shares one EGK binarizer engine (start/N in, code/length/done out) among NUM_REQ syntax-element requesters.

---
 rtl/egk_bin_scheduler.sv | 162 ++++++++++++++++
 tb/tb_egk_bin_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egk_bin_scheduler.sv
// Round-robin front end that shares one EGK binarizer engine among NUM_REQ syntax-element
// requesters, sequences the engine, watchdogs it, and buffers one result for the bin packer.
module egk_bin_scheduler #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned BIN_WIDTH   = 16,
    parameter int unsigned TIMEOUT     = 64,
    localparam int unsigned SrcW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned WdW        = $clog2(TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic                           eg_start_o,
    output logic [VALUE_WIDTH-1:0]         eg_value_o,
    input  logic [BIN_WIDTH-1:0]           eg_code_i,
    input  logic [BIN_WIDTH-1:0]           eg_len_i,
    input  logic                           eg_done_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [BIN_WIDTH-1:0]           out_code_o,
    output logic [BIN_WIDTH-1:0]           out_len_o,
    output logic [SrcW-1:0]                out_src_o,
    output logic                           timeout_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StHold
    } state_e;

    state_e                   state_q;
    logic [SrcW-1:0]          rr_q;
    logic [SrcW-1:0]          src_q;
    logic [WdW-1:0]           wd_q;
    logic [VALUE_WIDTH-1:0]   value_q;
    logic                     start_q;
    logic                     out_valid_q;
    logic [BIN_WIDTH-1:0]     out_code_q;
    logic [BIN_WIDTH-1:0]     out_len_q;
    logic [SrcW-1:0]          out_src_q;
    logic                     timeout_q;

    logic                     any_grant;
    logic [SrcW-1:0]          grant_idx;
    logic [SrcW-1:0]          rr_next;
    logic [NUM_REQ-1:0]       grant;
    logic [VALUE_WIDTH-1:0]   sel_value;
    logic                     wd_expired;
    int                       idx;

    // First valid requester at or after the round-robin pointer; only while idle with an
    // empty output register, so a buffered result can never be overwritten.
    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (state_q == StIdle && !out_valid_q) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                idx = int'(rr_q) + i;
                if (idx >= int'(NUM_REQ)) begin
                    idx = idx - int'(NUM_REQ);
                end
                if (!any_grant && req_valid_i[SrcW'(idx)]) begin
                    any_grant = 1'b1;
                    grant_idx = SrcW'(idx);
                end
            end
        end
    end

    always_comb begin
        grant     = '0;
        sel_value = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (grant_idx == SrcW'(r)) begin
                grant[r]  = any_grant;
                sel_value = req_value_i[r*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
        rr_next = (grant_idx == SrcW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Watchdog holds cycles elapsed since the start pulse.
    assign wd_expired = (wd_q >= WdW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            src_q       <= '0;
            wd_q        <= '0;
            value_q     <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_len_q   <= '0;
            out_src_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (any_grant) begin
                        value_q <= sel_value;
                        src_q   <= grant_idx;
                        rr_q    <= rr_next;
                        start_q <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    wd_q    <= WdW'(1);
                    state_q <= StWait;
                end
                StWait: begin
                    wd_q <= wd_q + 1'b1;
                    if (eg_done_i) begin
                        out_code_q  <= eg_code_i;
                        out_len_q   <= eg_len_i;
                        out_src_q   <= src_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StHold: begin
                    wd_q <= wd_q + 1'b1;
                    if (!eg_done_i) begin
                        state_q <= StIdle;
                    end else if (wd_expired) begin
                        // Engine stuck with done high: give up, result is already buffered.
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = grant;
    assign eg_start_o  = start_q;
    assign eg_value_o  = value_q;
    assign out_valid_o = out_valid_q;
    assign out_code_o  = out_code_q;
    assign out_len_o   = out_len_q;
    assign out_src_o   = out_src_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_egk_bin_scheduler.sv
// Randomized scoreboard bench for egk_bin_scheduler with an emulated EGK engine and an
// order-0 Exp-Golomb reference computed arithmetically.
module tb_egk_bin_scheduler;

    localparam int NR = 2;
    localparam int VW = 8;
    localparam int BW = 16;
    localparam int TO = 64;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid_i;
    logic [NR*VW-1:0]   req_value_i;
    logic [NR-1:0]      req_ready_o;
    logic               eg_start_o;
    logic [VW-1:0]      eg_value_o;
    logic [BW-1:0]      eg_code_i;
    logic [BW-1:0]      eg_len_i;
    logic               eg_done_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [BW-1:0]      out_code_o;
    logic [BW-1:0]      out_len_o;
    logic [0:0]         out_src_o;
    logic               timeout_o;
    logic               busy_o;

    egk_bin_scheduler #(
        .NUM_REQ     (NR),
        .VALUE_WIDTH (VW),
        .BIN_WIDTH   (BW),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_value_i (req_value_i),
        .req_ready_o (req_ready_o),
        .eg_start_o  (eg_start_o),
        .eg_value_o  (eg_value_o),
        .eg_code_i   (eg_code_i),
        .eg_len_i    (eg_len_i),
        .eg_done_i   (eg_done_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_code_o  (out_code_o),
        .out_len_o   (out_len_o),
        .out_src_o   (out_src_o),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [BW-1:0] code;
        logic [BW-1:0] len;
        logic [0:0]    src;
    } res_t;

    res_t         exp_q[$];
    logic [VW-1:0] q0[$];
    logic [VW-1:0] q1[$];
    logic [VW-1:0] start_q[$];
    int           grant_log[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rr_m = 0;
    int n_starts = 0;
    int eng_delay = 3;
    bit eng_mute = 0;
    bit late_req = 0;
    bit gap_en = 0;
    bit rand_ready = 0;
    bit stall = 0;
    bit log_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "bench aborted");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Order-0 Exp-Golomb of the signed value mapped to 0,1,-1,2,-2,... -> 0,1,2,3,4,...
    function automatic res_t model(input logic [VW-1:0] v, input int src);
        res_t r;
        int n, u, x, b;
        n = int'($signed(v));
        u = (n > 0) ? 2 * n - 1 : -2 * n;
        x = u + 1;
        b = 0;
        while ((x >> (b + 1)) != 0) b++;
        r.code = BW'(x);
        r.len  = BW'(2 * b + 1);
        r.src  = 1'(src);
        return r;
    endfunction

    function automatic int qsize(input int r);
        return (r == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [VW-1:0] qfront(input int r);
        return (r == 0) ? q0[0] : q1[0];
    endfunction

    // Requester and packer drivers.
    initial begin
        req_valid_i = '0;
        req_value_i = '0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (qsize(r) > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                    req_valid_i[r] = 1'b1;
                    req_value_i[r*VW +: VW] = qfront(r);
                end else begin
                    req_valid_i[r] = 1'b0;
                end
            end
            out_ready_i = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Grant observer: checks arbitration against the round-robin model and pushes expectations.
    initial forever begin
        logic [NR-1:0] g;
        logic [VW-1:0] v;
        int pred, act;
        @(negedge clk);
        if (rst_n) begin
            g = req_valid_i & req_ready_o;
            if (g != '0) begin
                pred = -1;
                for (int i = 0; i < NR; i++) begin
                    int k;
                    k = (rr_m + i) % NR;
                    if (pred < 0 && req_valid_i[k]) pred = k;
                end
                act = g[1] ? 1 : 0;
                check("grant_onehot", 64'($onehot(g)), 64'(1));
                check("grant_rr", 64'(act), 64'(pred));
                check("grant_while_out_full", 64'(out_valid_o), 64'(0));
                rr_m = (pred + 1) % NR;
                if (pred == 0) v = q0.pop_front();
                else v = q1.pop_front();
                start_q.push_back(v);
                if (!eng_mute) exp_q.push_back(model(v, pred));
                if (log_en) grant_log.push_back(act);
            end
        end
    end

    // Engine emulation: level done held 1-2 cycles, garbage on code/len otherwise.
    initial begin
        eg_done_i = 1'b0;
        eg_code_i = '0;
        eg_len_i  = '0;
        forever begin
            res_t r;
            int d, h;
            @(negedge clk);
            if (late_req) begin
                late_req = 0;
                @(posedge clk);
                #1;
                eg_done_i = 1'b1;
                eg_code_i = BW'($urandom);
                eg_len_i  = BW'($urandom);
                repeat (2) @(posedge clk);
                #1;
                eg_done_i = 1'b0;
            end else if (rst_n && eg_start_o) begin
                n_starts++;
                if (start_q.size() == 0) flag("start_without_grant");
                else check("eg_value", 64'(eg_value_o), 64'(start_q.pop_front()));
                if (!eng_mute) begin
                    d = (eng_delay > 0) ? eng_delay : $urandom_range(1, 6);
                    r = model(eg_value_o, 0);
                    repeat (d) @(posedge clk);
                    #1;
                    eg_done_i = 1'b1;
                    eg_code_i = r.code;
                    eg_len_i  = r.len;
                    h = $urandom_range(1, 2);
                    repeat (h) @(posedge clk);
                    #1;
                    eg_done_i = 1'b0;
                    eg_code_i = BW'($urandom);
                    eg_len_i  = BW'($urandom);
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks stability while stalled.
    initial begin
        bit   prev_v, prev_take;
        res_t prev, cur, e;
        prev_v = 0;
        prev_take = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
            end else begin
                cur = {out_code_o, out_len_o, out_src_o};
                if (prev_v && !prev_take) begin
                    check("out_valid_held", 64'(out_valid_o), 64'(1));
                    if (out_valid_o) check("out_regs_stable", 64'(cur), 64'(prev));
                end
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        flag("out_unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("out_code", 64'(out_code_o), 64'(e.code));
                        check("out_len", 64'(out_len_o), 64'(e.len));
                        check("out_src", 64'(out_src_o), 64'(e.src));
                    end
                end
                prev_v = out_valid_o;
                prev_take = out_ready_i;
                prev = cur;
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || out_valid_o) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) flag("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(output int c0);
        int t = 0;
        while (!eg_start_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) flag("wait_start_timeout");
        c0 = cyc;
    endtask

    initial begin
        int c0, t;
        bit seen_v, seen_b;
        int s0;
        logic [VW-1:0] sweep [4];

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'(0));
        check("rst_eg_start", 64'(eg_start_o), 64'(0));
        check("rst_eg_value", 64'(eg_value_o), 64'(0));
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_out_code", 64'(out_code_o), 64'(0));
        check("rst_out_len", 64'(out_len_o), 64'(0));
        check("rst_timeout", 64'(timeout_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, engine done 3 cycles after start.
        s0 = n_starts;
        q0.push_back(8'd5);
        wait_start(c0);
        t = 0;
        while (!out_valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t1_latency", 64'(cyc - c0), 64'(4));
        drain();
        check("t1_start_count", 64'(n_starts - s0), 64'(1));
        check("t1_busy_after", 64'(busy_o), 64'(0));

        // Two requesters valid continuously must alternate.
        log_en = 1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'hFD);
            q1.push_back(8'd6);
        end
        drain();
        log_en = 0;
        check("t2_grant_count", 64'(grant_log.size()), 64'(8));
        for (int i = 1; i < grant_log.size(); i++)
            check("t2_alternate", 64'(grant_log[i] != grant_log[i-1]), 64'(1));

        // Stalled packer blocks further grants and engine starts.
        stall = 1;
        q0.push_back(8'd17);
        t = 0;
        while (!out_valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        q1.push_back(8'hF7);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t3_ready_blocked", 64'(req_ready_o), 64'(0));
            check("t3_no_start", 64'(eg_start_o), 64'(0));
            check("t3_out_valid", 64'(out_valid_o), 64'(1));
            @(negedge clk);
        end
        stall = 0;
        drain();

        // Sweep via requester 1 only, random engine latency.
        eng_delay = 0;
        sweep[0] = 8'd0;
        sweep[1] = 8'hFF;
        sweep[2] = 8'hFE;
        sweep[3] = 8'd7;
        for (int i = 0; i < 4; i++) q1.push_back(sweep[i]);
        drain();

        // Random traffic with valid gaps and packer backpressure.
        gap_en = 1;
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(VW'($urandom));
            else q1.push_back(VW'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();
        gap_en = 0;
        rand_ready = 0;

        // Engine never answers: watchdog fires 64 cycles after the start pulse.
        check("t4_timeout_before", 64'(timeout_o), 64'(0));
        eng_mute = 1;
        q0.push_back(8'd33);
        wait_start(c0);
        t = 0;
        seen_v = 0;
        while (!timeout_o && t < 200) begin
            @(negedge clk);
            t++;
            if (out_valid_o) seen_v = 1;
        end
        check("t4_timeout_cycles", 64'(cyc - c0), 64'(TO));
        check("t4_no_output", 64'(seen_v), 64'(0));
        repeat (2) @(negedge clk);
        check("t4_busy_after_abort", 64'(busy_o), 64'(0));
        eng_mute = 0;
        q1.push_back(8'hEC);
        drain();
        check("t4_timeout_sticky", 64'(timeout_o), 64'(1));

        // Reset while the engine is busy; a late done must not produce a result.
        eng_mute = 1;
        q0.push_back(8'hFC);
        wait_start(c0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_eg_start", 64'(eg_start_o), 64'(0));
        check("t5_eg_value", 64'(eg_value_o), 64'(0));
        check("t5_out_valid", 64'(out_valid_o), 64'(0));
        check("t5_timeout_cleared", 64'(timeout_o), 64'(0));
        check("t5_busy", 64'(busy_o), 64'(0));
        check("t5_req_ready", 64'(req_ready_o), 64'(0));
        q0.delete();
        q1.delete();
        exp_q.delete();
        start_q.delete();
        rr_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_req = 1;
        seen_v = 0;
        seen_b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_o) seen_v = 1;
            if (busy_o) seen_b = 1;
        end
        check("t5_late_done_no_output", 64'(seen_v), 64'(0));
        check("t5_late_done_not_busy", 64'(seen_b), 64'(0));
        eng_mute = 0;
        eng_delay = 2;
        q0.push_back(8'd12);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
